// File: rtl/tx_scheduler.sv
// Round-robin scheduler that shares one transmitter between N_REQ requesters:
// one register write, one launch, then waits on readydata to finish or time out.
module tx_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ACK_TO  = 16,
  parameter int XFER_TO = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_cfg,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     err,
  output logic                 busy,
  output logic                 write,
  output logic [3:0]           addin,
  output logic [7:0]           data,
  output logic                 startTx,
  output logic [31:0]          txdata,
  input  logic                 readydata,
  output logic [2:0]           dbg_state
);

  // Handshake: req[i] is a level held by requester i until done[i] or err[i]
  // pulses for one cycle; gnt[i] marks ownership from CFG through DONE/ERR.

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_START = 3'd2,
    S_ACK   = 3'd3,
    S_XFER  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   txdata_q, txdata_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic [N_REQ-1:0] owner;

  // Search starts one past the last owner, so the last owner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((32'(ptr_q) + 32'(i)) % 32'(N_REQ));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ptr_q    <= IW'(N_REQ - 1);
      cnt_q    <= '0;
      txdata_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      txdata_q <= txdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    txdata_d = txdata_q;
    case (state_q)
      S_IDLE: begin
        if (readydata && win_found) begin
          idx_d   = win_idx;
          state_d = S_CFG;
        end
      end
      S_CFG: state_d = S_START;
      S_START: begin
        txdata_d = req_data[32*idx_q +: 32];
        cnt_d    = '0;
        state_d  = S_ACK;
      end
      S_ACK: begin
        if (!readydata) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end else if (cnt_q == 16'(ACK_TO - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_XFER: begin
        if (readydata) begin
          state_d = S_DONE;
        end else if (cnt_q == 16'(XFER_TO - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE, S_ERR: begin
        ptr_d   = idx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state and idx; addin/data/txdata pass the
  // requester's inputs through only in the cycle they are consumed.
  always_comb begin
    owner     = N_REQ'(1) << idx_q;
    busy      = (state_q != S_IDLE);
    gnt       = busy ? owner : '0;
    done      = (state_q == S_DONE) ? owner : '0;
    err       = (state_q == S_ERR) ? owner : '0;
    write     = (state_q == S_CFG);
    addin     = (state_q == S_CFG) ? req_addr[4*idx_q +: 4] : 4'd0;
    data      = (state_q == S_CFG) ? req_cfg[8*idx_q +: 8] : 8'd0;
    startTx   = (state_q == S_START);
    txdata    = (state_q == S_START) ? req_data[32*idx_q +: 32] : txdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: the bench plays the transmitter by driving
// readydata by hand; outputs are sampled 1 time unit after each rising edge.
module tb_tx_scheduler;

  localparam int N_REQ   = 4;
  localparam int ACK_TO  = 16;
  localparam int XFER_TO = 64;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACK  = 3'd3;
  localparam logic [2:0] ST_XFER = 3'd4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  logic [4*N_REQ-1:0]   req_addr = '0;
  logic [8*N_REQ-1:0]   req_cfg = '0;
  logic [32*N_REQ-1:0]  req_data = '0;
  logic                 readydata = 1'b1;
  logic [N_REQ-1:0]     gnt, done, err;
  logic                 busy, write, startTx;
  logic [3:0]           addin;
  logic [7:0]           data;
  logic [31:0]          txdata;
  logic [2:0]           dbg_state;

  int checks = 0;
  int errors = 0;

  tx_scheduler #(.N_REQ(N_REQ), .ACK_TO(ACK_TO), .XFER_TO(XFER_TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_cfg(req_cfg),
    .req_data(req_data), .gnt(gnt), .done(done), .err(err), .busy(busy),
    .write(write), .addin(addin), .data(data), .startTx(startTx), .txdata(txdata),
    .readydata(readydata), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // All outputs packed together: gnt,done,err,busy,write,addin,data,startTx,txdata.
  function automatic logic [63:0] all_outs();
    return 64'({gnt, done, err, busy, write, addin, data, startTx, txdata});
  endfunction

  // One normal transaction from IDLE: readydata drops in the first ACK cycle
  // and rises in the first XFER cycle.
  task automatic do_txn(input string tag, input logic [3:0] g, input logic [31:0] td);
    step();
    check({tag, "_cfg_gnt"}, 64'(gnt), 64'(g));
    check({tag, "_cfg_strobes"}, 64'({write, startTx}), 64'b10);
    step();
    check({tag, "_start_strobes"}, 64'({write, startTx}), 64'b01);
    check({tag, "_txdata"}, 64'(txdata), 64'(td));
    step();
    readydata = 1'b0;
    step();
    check({tag, "_xfer"}, 64'(dbg_state), 64'(ST_XFER));
    readydata = 1'b1;
    step();
    check({tag, "_done"}, 64'({done, err, gnt}), 64'({g, 4'b0000, g}));
    step();
    check({tag, "_idle"}, 64'({busy, gnt, done}), 64'd0);
  endtask

  initial begin : main
    logic saw_bad;

    req_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    req_addr = {4'h6, 4'h5, 4'h4, 4'h3};
    req_cfg  = {8'h44, 8'h33, 8'h22, 8'hA5};

    // Reset state.
    #1;
    check("reset_outs", all_outs(), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    step();
    step();
    reset = 1'b1;

    // Single request from requester 0.
    req = 4'b0001;
    step();
    check("single_cfg", 64'({gnt, write, startTx, addin, data, busy}), 64'({4'b0001, 2'b10, 4'h3, 8'hA5, 1'b1}));
    step();
    check("single_start", 64'({write, startTx, addin, data}), 64'({2'b01, 12'h000}));
    check("single_txdata", 64'(txdata), 64'h0000_0000_DEAD_BEEF);
    step();
    check("single_ack", 64'({dbg_state, startTx}), 64'({ST_ACK, 1'b0}));
    step();
    readydata = 1'b0;
    step();
    check("single_xfer", 64'(dbg_state), 64'(ST_XFER));
    saw_bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (done != 0 || err != 0 || dbg_state != ST_XFER) saw_bad = 1'b1;
    end
    check("single_wait", 64'(saw_bad), 64'd0);
    readydata = 1'b1;
    step();
    check("single_done", 64'({done, err, gnt}), 64'({4'b0001, 4'b0000, 4'b0001}));
    req = 4'b0000;
    step();
    check("single_idle", 64'({busy, gnt, done, err}), 64'd0);
    check("single_hold", 64'(txdata), 64'h0000_0000_DEAD_BEEF);

    // Fairness: last owner was 0, so the rotation starts at 1.
    req = 4'b1111;
    do_txn("rr1", 4'b0010, 32'h1111_1111);
    do_txn("rr2", 4'b0100, 32'h2222_2222);
    do_txn("rr3", 4'b1000, 32'h3333_3333);
    do_txn("rr0", 4'b0001, 32'hDEAD_BEEF);
    do_txn("rr1b", 4'b0010, 32'h1111_1111);
    req = 4'b0000;

    // Ack timeout: ptr=1, req=0110 -> requester 2. ACK lasts ACK_TO cycles,
    // so err lands ACK_TO+1 cycles after the startTx cycle.
    req = 4'b0110;
    step();
    check("ackto_gnt", 64'(gnt), 64'b0100);
    step();
    step();
    check("ackto_entry", 64'(dbg_state), 64'(ST_ACK));
    for (int i = 0; i < ACK_TO - 1; i++) step();
    check("ackto_still_ack", 64'({dbg_state, err}), 64'({ST_ACK, 4'b0000}));
    step();
    check("ackto_err", 64'({err, done, gnt, busy}), 64'({4'b0100, 4'b0000, 4'b0100, 1'b1}));
    req = 4'b1000;
    step();
    check("ackto_idle", 64'({busy, err}), 64'd0);
    do_txn("ackto_next", 4'b1000, 32'h3333_3333);
    req = 4'b0000;

    // Transfer timeout: ptr=3, req=0100 -> requester 2.
    req = 4'b0100;
    step();
    check("xto_gnt", 64'(gnt), 64'b0100);
    step();
    step();
    readydata = 1'b0;
    step();
    check("xto_entry", 64'(dbg_state), 64'(ST_XFER));
    saw_bad = 1'b0;
    for (int i = 0; i < XFER_TO - 1; i++) begin
      step();
      if (!busy || dbg_state != ST_XFER || err != 0) saw_bad = 1'b1;
    end
    check("xto_wait", 64'(saw_bad), 64'd0);
    step();
    check("xto_err", 64'({err, busy}), 64'({4'b0100, 1'b1}));
    readydata = 1'b1;
    req = 4'b0000;
    step();
    check("xto_idle", 64'({busy, err}), 64'd0);

    // Busy transmitter at idle: no grant while readydata is low.
    readydata = 1'b0;
    req = 4'b0010;
    saw_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt != 0 || busy) saw_bad = 1'b1;
    end
    check("busytx_nogrant", 64'(saw_bad), 64'd0);
    readydata = 1'b1;
    step();
    check("busytx_gnt", 64'(gnt), 64'b0010);

    // Reset while in XFER.
    step();
    step();
    readydata = 1'b0;
    step();
    check("rst_pre_xfer", 64'(dbg_state), 64'(ST_XFER));
    reset = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 64'd0);
    check("rst_async_state", 64'(dbg_state), 64'(ST_IDLE));
    req = 4'b1001;
    readydata = 1'b1;
    step();
    reset = 1'b1;
    step();
    check("rst_first_gnt", 64'(gnt), 64'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
